cs161_fetch_unit: RTL and testbench

//   Instruction fetch stage ahead of the cs161_processor control/datapath. Holds the PC and issues

---
 rtl/cs161_pkg.sv | 20 ++
 rtl/cs161_fetch_buffer.sv | 54 +++++
 rtl/cs161_fetch_unit.sv | 103 ++++++++++
 tb/tb_cs161_fetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cs161_pkg.sv
// Shared definitions for the cs161 fetch stage and control unit.
// Covers fetch FSM state encodings, word size and opcode field position.
package cs161_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  localparam int unsigned WORD_BYTES       = 4;
  localparam int unsigned OPCODE_MSB       = 31;
  localparam int unsigned OPCODE_LSB       = 26;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cs161_fetch_buffer.sv
// Small FIFO of fetched {pc, instr} pairs feeding decode.
// Flush wins over push and pop in the same cycle.
module cs161_fetch_buffer
  import cs161_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2,
  localparam int unsigned PtrW = $clog2(BUF_DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [31:0]     push_pc,
  input  logic [31:0]     push_instr,
  output logic [31:0]     head_pc,
  output logic [31:0]     head_instr,
  output logic [CntW-1:0] count
);

  logic [63:0]     mem_q [BUF_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count_q != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_pc, push_instr};
  end

  assign {head_pc, head_instr} = mem_q[rd_ptr_q];
  assign count                 = count_q;

endmodule

// File: rtl/cs161_fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem request FSM,
// fetch FIFO toward decode, and redirect handling that drops stale responses.
module cs161_fetch_unit
  import cs161_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [5:0]  instr_opcode,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] count;
  logic [31:0]     head_pc, head_instr;
  logic            outstanding, space, req_valid, req_hs, push, pop;

  assign outstanding = (state_q != S_REQ);
  assign space       = (32'(count) + 32'(outstanding)) < BUF_DEPTH;
  assign req_valid   = (state_q == S_REQ) & space;
  assign req_hs      = req_valid & imem_req_ready;
  assign push        = (state_q == S_WAIT) & imem_resp_valid & ~redirect_valid;
  assign pop         = (count != '0) & instr_ready & ~redirect_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (req_hs) fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
    case (state_q)
      S_REQ:   if (req_hs) state_d = S_WAIT;
      S_WAIT:  if (imem_resp_valid) state_d = S_REQ;
      S_DROP:  if (imem_resp_valid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
    // A redirect leaves exactly one stale response owed unless it lands this cycle.
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      case (state_q)
        S_REQ:   state_d = req_hs ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem_resp_valid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_resp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == S_REQ) begin
      assert (!imem_resp_valid)
        else $error("imem_resp_valid with no request outstanding");
    end
  end

  cs161_fetch_buffer #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_pc    (fetch_pc_q - 32'(WORD_BYTES)),
    .push_instr (imem_resp_data),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (count)
  );

  assign imem_req_valid = ~rst & req_valid;
  assign imem_req_addr  = rst ? '0 : fetch_pc_q;
  assign instr_valid    = ~rst & (count != '0);
  assign instr_data     = rst ? '0 : head_instr;
  assign instr_opcode   = instr_data[OPCODE_MSB:OPCODE_LSB];
  assign instr_pc       = rst ? '0 : head_pc;
  assign instr_pc_plus4 = rst ? '0 : head_pc + 32'(WORD_BYTES);

endmodule

// File: tb/tb_cs161_fetch_unit.sv
// Bench for cs161_fetch_unit: directed scenarios plus a randomized run
// scored against an in-order fetch-stream model with a behavioural imem.
module tb_cs161_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, imem_req_ready, imem_resp_valid, redirect_valid, instr_ready;
  logic [31:0] imem_resp_data, w_resp_data, redirect_pc;
  logic        req_valid, instr_valid, w_req_valid, w_instr_valid;
  logic [31:0] req_addr, instr_data, instr_pc, instr_pc_plus4;
  logic [31:0] w_req_addr, w_instr_data, w_instr_pc, w_instr_pc_plus4;
  logic [5:0]  instr_opcode, w_instr_opcode;

  always #5 clk = ~clk;

  cs161_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk (clk), .rst (rst),
    .imem_req_valid (req_valid), .imem_req_ready (imem_req_ready), .imem_req_addr (req_addr),
    .imem_resp_valid (imem_resp_valid), .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
    .instr_valid (instr_valid), .instr_ready (instr_ready), .instr_data (instr_data),
    .instr_opcode (instr_opcode), .instr_pc (instr_pc), .instr_pc_plus4 (instr_pc_plus4)
  );

  // Same control flow as dut (addresses never steer timing), so it shares handshake inputs.
  cs161_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_wrap (
    .clk (clk), .rst (rst),
    .imem_req_valid (w_req_valid), .imem_req_ready (imem_req_ready), .imem_req_addr (w_req_addr),
    .imem_resp_valid (imem_resp_valid), .imem_resp_data (w_resp_data),
    .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
    .instr_valid (w_instr_valid), .instr_ready (instr_ready), .instr_data (w_instr_data),
    .instr_opcode (w_instr_opcode), .instr_pc (w_instr_pc), .instr_pc_plus4 (w_instr_pc_plus4)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc, resp_lat;
  bit rand_lat;
  logic [31:0] pend_addr[$], w_pend[$], acc_addr[$], w_acc[$];
  int          pend_due[$], got_cyc[$];
  logic [31:0] got_pc[$], got_data[$], got_p4[$], w_got_pc[$], w_got_data[$], w_got_p4[$];
  logic [5:0]  got_op[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {a[7:2], 26'h0};
  endfunction

  // One clock cycle: imem model responds/accepts, decode handshakes are recorded.
  task automatic tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    w_resp_data     = '0;
    if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_addr[0]);
      if (w_pend.size() != 0) w_resp_data = mem_word(w_pend[0]);
    end
    #1;
    if (imem_resp_valid) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
      if (w_pend.size() != 0) void'(w_pend.pop_front());
    end
    if (req_valid && imem_req_ready) begin
      acc_addr.push_back(req_addr);
      pend_addr.push_back(req_addr);
      pend_due.push_back(cyc + (rand_lat ? int'($urandom_range(1, 3)) : resp_lat));
    end
    if (w_req_valid && imem_req_ready) begin
      w_acc.push_back(w_req_addr);
      w_pend.push_back(w_req_addr);
    end
    if (instr_valid && instr_ready && !redirect_valid) begin
      got_pc.push_back(instr_pc);
      got_data.push_back(instr_data);
      got_p4.push_back(instr_pc_plus4);
      got_op.push_back(instr_opcode);
      got_cyc.push_back(cyc);
    end
    if (w_instr_valid && instr_ready && !redirect_valid) begin
      w_got_pc.push_back(w_instr_pc);
      w_got_data.push_back(w_instr_data);
      w_got_p4.push_back(w_instr_pc_plus4);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; w_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    resp_lat = 1; rand_lat = 1'b0;
    pend_addr.delete(); pend_due.delete(); w_pend.delete(); acc_addr.delete(); w_acc.delete();
    got_pc.delete(); got_data.delete(); got_p4.delete(); got_op.delete(); got_cyc.delete();
    w_got_pc.delete(); w_got_data.delete(); w_got_p4.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start();
    hold_reset();
    rst = 1'b0;
    cyc = 0;
    #1;
  endtask

  task automatic test_reset();
    hold_reset();
    #1;
    n_vec++;
    if ({req_valid, instr_valid, w_req_valid, w_instr_valid} !== 4'b0) begin
      n_bad++; $display("FAIL reset_valids: got %b want 0000",
                        {req_valid, instr_valid, w_req_valid, w_instr_valid});
    end
    n_vec++;
    if ({req_addr, instr_data, instr_pc, instr_pc_plus4, w_req_addr} !== 160'h0) begin
      n_bad++; $display("FAIL reset_data: addr %h data %h pc %h p4 %h waddr %h want all 0",
                        req_addr, instr_data, instr_pc, instr_pc_plus4, w_req_addr);
    end
    rst = 1'b0;
    cyc = 0;
    #1;
    n_vec++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0 || instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL first_req: valid %b addr %h ivalid %b want 1 0 0",
                        req_valid, req_addr, instr_valid);
    end
    n_vec++;
    if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFF8) begin
      n_bad++; $display("FAIL first_req_wrap: valid %b addr %h want 1 fffffff8",
                        w_req_valid, w_req_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] w;
    start();
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (9) tick();
    n_vec++;
    if (got_pc.size() !== 4) begin
      n_bad++; $display("FAIL stream_count: got %0d want 4", got_pc.size());
    end
    for (int i = 0; i < got_pc.size() && i < 4; i++) begin
      w = mem_word(32'(4 * i));
      n_vec++;
      if (got_pc[i] !== 32'(4 * i) || got_data[i] !== w || got_op[i] !== w[31:26]
          || got_p4[i] !== 32'(4 * i + 4) || got_cyc[i] !== 2 + 2 * i) begin
        n_bad++; $display("FAIL stream[%0d]: pc %h data %h op %h p4 %h cyc %0d want %h %h %h %h %0d",
                          i, got_pc[i], got_data[i], got_op[i], got_p4[i], got_cyc[i],
                          32'(4 * i), w, w[31:26], 32'(4 * i + 4), 2 + 2 * i);
      end
    end
  endtask

  task automatic test_decode_stall();
    start();
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) begin
        n_vec++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== mem_word(32'h0)) begin
          n_bad++; $display("FAIL stall_head c%0d: valid %b pc %h data %h want 1 0 %h",
                            i, instr_valid, instr_pc, instr_data, mem_word(32'h0));
        end
      end
      if (i >= 4) begin
        n_vec++;
        if (req_valid !== 1'b0) begin
          n_bad++; $display("FAIL stall_req c%0d: req_valid %b want 0", i, req_valid);
        end
      end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    n_vec++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || got_pc.size() !== 1) begin
      n_bad++; $display("FAIL stall_second: valid %b pc %h pops %0d want 1 4 1",
                        instr_valid, instr_pc, got_pc.size());
    end
  endtask

  task automatic test_req_stall();
    start();
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (req_valid !== 1'b1 || req_addr !== 32'h4) begin
        n_bad++; $display("FAIL req_hold[%0d]: valid %b addr %h want 1 4", i, req_valid, req_addr);
      end
      tick();
    end
    imem_req_ready = 1'b1;
    repeat (6) tick();
    n_vec++;
    if (acc_addr.size() < 3 || acc_addr[1] !== 32'h4 || acc_addr[2] !== 32'h8) begin
      n_bad++; $display("FAIL req_resume: accepted %0d addrs, [1]=%h [2]=%h want 4 8",
                        acc_addr.size(), acc_addr.size() > 1 ? acc_addr[1] : 32'hx,
                        acc_addr.size() > 2 ? acc_addr[2] : 32'hx);
    end
  endtask

  task automatic test_redirect_wait();
    start();
    imem_req_ready = 1'b1; instr_ready = 1'b1; resp_lat = 2;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    n_vec++;
    if (instr_valid !== 1'b0 || req_valid !== 1'b0) begin
      n_bad++; $display("FAIL redir_wait_drop: ivalid %b req %b want 0 0", instr_valid, req_valid);
    end
    resp_lat = 1;
    tick();
    n_vec++;
    if (req_valid !== 1'b1 || req_addr !== 32'h100 || instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL redir_wait_req: req %b addr %h ivalid %b want 1 100 0",
                        req_valid, req_addr, instr_valid);
    end
    repeat (4) tick();
    n_vec++;
    if (got_pc.size() == 0 || got_pc[0] !== 32'h100 || got_data[0] !== mem_word(32'h100)) begin
      n_bad++; $display("FAIL redir_wait_first: n %0d pc %h data %h want pc 100 data %h",
                        got_pc.size(), got_pc.size() ? got_pc[0] : 32'hx,
                        got_data.size() ? got_data[0] : 32'hx, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_resp();
    start();
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      n_bad++; $display("FAIL redir_resp_pre: ivalid %b pc %h want 1 0", instr_valid, instr_pc);
    end
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    n_vec++;
    if (instr_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h200) begin
      n_bad++; $display("FAIL redir_resp_post: ivalid %b req %b addr %h want 0 1 200",
                        instr_valid, req_valid, req_addr);
    end
    repeat (4) tick();
    n_vec++;
    if (got_pc.size() == 0 || got_pc[0] !== 32'h200) begin
      n_bad++; $display("FAIL redir_resp_first: n %0d pc %h want 200",
                        got_pc.size(), got_pc.size() ? got_pc[0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pc;
    start();
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (9) tick();
    n_vec++;
    if (w_got_pc.size() !== 4) begin
      n_bad++; $display("FAIL wrap_count: got %0d want 4", w_got_pc.size());
    end
    for (int i = 0; i < w_got_pc.size() && i < 4; i++) begin
      pc = 32'hFFFF_FFF8 + 32'(4 * i);
      n_vec++;
      if (w_got_pc[i] !== pc || w_got_data[i] !== mem_word(pc) || w_got_p4[i] !== pc + 32'd4) begin
        n_bad++; $display("FAIL wrap[%0d]: pc %h data %h p4 %h want %h %h %h", i, w_got_pc[i],
                          w_got_data[i], w_got_p4[i], pc, mem_word(pc), pc + 32'd4);
      end
    end
    n_vec++;
    if (w_got_p4.size() < 2 || w_got_p4[1] !== 32'h0) begin
      n_bad++; $display("FAIL wrap_p4: pc+4 of fffffffc is %h want 0",
                        w_got_p4.size() > 1 ? w_got_p4[1] : 32'hx);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, hold_addr, prev_pc, prev_data, tgt;
    bit          req_pend, hold, redir;
    int          n_deliv;
    start();
    rand_lat = 1'b1;
    exp_pc = 32'h0; req_pend = 1'b0; hold = 1'b0; n_deliv = 0;
    hold_addr = '0; prev_pc = '0; prev_data = '0;
    for (int i = 0; i < 3000; i++) begin
      if (req_pend) begin
        n_vec++;
        if (req_valid !== 1'b1 || req_addr !== hold_addr) begin
          n_bad++; $display("FAIL rnd_req_hold c%0d: valid %b addr %h want 1 %h",
                            cyc, req_valid, req_addr, hold_addr);
        end
      end
      if (hold) begin
        n_vec++;
        if (instr_valid !== 1'b1 || instr_pc !== prev_pc || instr_data !== prev_data) begin
          n_bad++; $display("FAIL rnd_head_hold c%0d: valid %b pc %h data %h want 1 %h %h",
                            cyc, instr_valid, instr_pc, instr_data, prev_pc, prev_data);
        end
      end
      if (req_valid) begin
        n_vec++;
        if (req_addr[1:0] !== 2'b00) begin
          n_bad++; $display("FAIL rnd_align c%0d: addr %h", cyc, req_addr);
        end
      end
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 4) < 3);
      redir          = ($urandom_range(0, 29) == 0);
      tgt            = $urandom;
      if (redir) begin
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
      end
      req_pend  = req_valid && !imem_req_ready;
      hold_addr = redir ? (tgt & ~32'h3) : req_addr;
      hold      = instr_valid && !instr_ready && !redir;
      prev_pc   = instr_pc;
      prev_data = instr_data;
      tick();
      while (got_pc.size() != 0) begin
        n_vec++;
        if (got_pc[0] !== exp_pc || got_data[0] !== mem_word(exp_pc)
            || got_p4[0] !== exp_pc + 32'd4 || got_op[0] !== got_data[0][31:26]) begin
          n_bad++; $display("FAIL rnd_stream c%0d: pc %h data %h p4 %h op %h want pc %h data %h",
                            cyc, got_pc[0], got_data[0], got_p4[0], got_op[0],
                            exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
        void'(got_pc.pop_front()); void'(got_data.pop_front()); void'(got_p4.pop_front());
        void'(got_op.pop_front()); void'(got_cyc.pop_front());
      end
      if (redir) exp_pc = tgt & ~32'h3;
    end
    n_vec++;
    if (n_deliv < 200) begin
      n_bad++; $display("FAIL rnd_progress: delivered %0d want >= 200", n_deliv);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_decode_stall();
    test_req_stall();
    test_redirect_wait();
    test_redirect_resp();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
